// File: rtl/pipe_reg_exmem_elastic.sv
// EX/MEM pipeline register with valid/ready flow control, synchronous flush and an optional skid entry.
// Handshake: a beat moves on a side at a rising clk edge where valid && ready; the producer holds valid and payload stable until then.
module pipe_reg_exmem_elastic #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit SKID       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_alu_out,
    input  logic [XLEN-1:0]       in_new_PC,
    input  logic                  in_branch_taken,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_mem_data,
    input  logic                  in_mem_write,
    input  logic                  in_mem_read,
    input  logic                  in_branch_inst,
    input  logic                  in_mem_to_reg,
    input  logic                  in_write_enable,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_alu_out,
    output logic [XLEN-1:0]       out_new_PC,
    output logic [XLEN-1:0]       out_mem_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_branch_taken,
    output logic                  out_mem_write,
    output logic                  out_mem_read,
    output logic                  out_branch_inst,
    output logic                  out_mem_to_reg,
    output logic                  out_write_enable
);

    typedef struct packed {
        logic [XLEN-1:0]       alu_out;
        logic [XLEN-1:0]       new_pc;
        logic [XLEN-1:0]       mem_data;
        logic [REG_ADDR_W-1:0] rd;
    } payload_t;

    typedef struct packed {
        logic branch_taken;
        logic mem_write;
        logic mem_read;
        logic branch_inst;
        logic mem_to_reg;
        logic write_enable;
    } ctrl_t;

    payload_t in_pl;
    ctrl_t    in_ctrl;
    payload_t main_pl;
    ctrl_t    main_ctrl;
    logic     main_valid;
    logic     accept;
    logic     main_free;

    assign in_pl     = {in_alu_out, in_new_PC, in_mem_data, in_rd};
    assign in_ctrl   = {in_branch_taken, in_mem_write, in_mem_read,
                        in_branch_inst, in_mem_to_reg, in_write_enable};
    assign accept    = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;

    generate
        if (SKID) begin : g_skid
            payload_t skid_pl;
            ctrl_t    skid_ctrl;
            logic     skid_valid;

            // Ready depends only on the skid flop, so out_ready never reaches in_ready.
            assign in_ready = !skid_valid;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    main_valid <= 1'b0;
                    main_pl    <= '0;
                    main_ctrl  <= '0;
                    skid_valid <= 1'b0;
                    skid_pl    <= '0;
                    skid_ctrl  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                    skid_valid <= 1'b0;
                    skid_ctrl  <= '0;
                end else if (main_free) begin
                    if (skid_valid) begin
                        main_pl    <= skid_pl;
                        main_ctrl  <= skid_ctrl;
                        skid_valid <= 1'b0;
                        skid_ctrl  <= '0;
                    end else if (accept) begin
                        main_valid <= 1'b1;
                        main_pl    <= in_pl;
                        main_ctrl  <= in_ctrl;
                    end else begin
                        // Bubble: drop the control bits, keep the payload bits as they were.
                        main_valid <= 1'b0;
                        main_ctrl  <= '0;
                    end
                end else if (accept) begin
                    skid_valid <= 1'b1;
                    skid_pl    <= in_pl;
                    skid_ctrl  <= in_ctrl;
                end
            end
        end else begin : g_single
            assign in_ready = main_free;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    main_valid <= 1'b0;
                    main_pl    <= '0;
                    main_ctrl  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end else if (accept) begin
                    main_valid <= 1'b1;
                    main_pl    <= in_pl;
                    main_ctrl  <= in_ctrl;
                end else if (main_valid && out_ready) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end
            end
        end
    endgenerate

    assign out_valid        = main_valid;
    assign out_alu_out      = main_pl.alu_out;
    assign out_new_PC       = main_pl.new_pc;
    assign out_mem_data     = main_pl.mem_data;
    assign out_rd           = main_pl.rd;
    assign out_branch_taken = main_ctrl.branch_taken;
    assign out_mem_write    = main_ctrl.mem_write;
    assign out_mem_read     = main_ctrl.mem_read;
    assign out_branch_inst  = main_ctrl.branch_inst;
    assign out_mem_to_reg   = main_ctrl.mem_to_reg;
    assign out_write_enable = main_ctrl.write_enable;

endmodule

// File: doc/pipe_reg_exmem_elastic.md
Name: pipe_reg_exmem_elastic

Overview:
- Parametrised EX/MEM pipeline stage with a valid/ready handshake and an optional skid entry.
- Carries the ALU result, redirect PC, branch status, store data, rd and MEM/WB control bits from EX to MEM.
- Adds three behaviours to the plain always-load register: back-pressure from MEM (data-cache miss stall), a synchronous flush (branch mispredict or trap), and bubble-clean control outputs.
- Sits between the EX stage and the data-memory interface in the core pipeline.

Parameters:
XLEN, 32, width of alu_out, new_PC and mem_data.
REG_ADDR_W, 5, width of rd.
SKID, 1, 1 = two-entry (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
flush  in  1  synchronous kill of all held and incoming beats.
in_valid  in  1  EX presents a beat.
in_ready  out  1  stage accepts the beat this cycle.
in_alu_out  in  XLEN  ALU result / memory address.
in_new_PC  in  XLEN  branch/jump target.
in_branch_taken  in  1  branch resolved taken.
in_rd  in  REG_ADDR_W  destination register.
in_mem_data  in  XLEN  store data.
in_mem_write, in_mem_read, in_branch_inst, in_mem_to_reg, in_write_enable  in  1 each  control bits.
out_valid  out  1  MEM-side beat valid.
out_ready  in  1  MEM consumes the beat this cycle.
out_alu_out, out_new_PC, out_mem_data  out  XLEN  registered payload.
out_rd  out  REG_ADDR_W  registered rd.
out_branch_taken, out_mem_write, out_mem_read, out_branch_inst, out_mem_to_reg, out_write_enable  out  1 each  registered control bits.

Behaviour:
- Reset (reset=0, asynchronous):
  - All out_* = 0, out_valid = 0, skid entry invalid.
  - in_ready = 1 while in reset and on the first cycle after release.
- Handshake:
  - Accept when in_valid && in_ready.
  - Deliver when out_valid && out_ready.
  - in_valid may rise regardless of in_ready.
  - Once asserted, EX holds the payload stable until accepted.
- SKID=1:
  - in_ready = !skid_valid, a pure register output (no combinational path from out_ready).
  - Main empty or delivering this cycle: main loads from skid if skid_valid, else from the input if accepted, else goes invalid.
  - Main held (out_valid && !out_ready) and input accepted: beat goes to skid; in_ready drops next cycle.
  - Skid drains into main on the first delivering cycle. in_ready returns to 1 the cycle after.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - Main loads on accept. out_valid clears on deliver without accept.
- Latency: 1 cycle from accept to out_valid when unstalled. Sustained throughput is 1 beat/cycle in both modes.
- Order: beats always leave in acceptance order. No beat is duplicated or lost except by flush.
- Stall: while out_valid && !out_ready, every out_* is held bit-stable.
- Bubble cleanliness: whenever out_valid=0, all six control outputs read 0. Payload outputs (alu_out, new_PC, mem_data, rd) keep their last value.
- Flush (synchronous):
  - Priority: above all except reset.
  - Next cycle: out_valid=0, skid invalid, control outputs 0.
  - A beat accepted in the flush cycle is discarded.
  - A beat delivered in the flush cycle counts as delivered.
  - in_ready=1 the cycle after flush (SKID=1).
- Simultaneous flush and out_ready=0: flush wins; the held beat is dropped.
- Reset mid-stall or with skid full: both entries cleared immediately; no beat survives.
- No arithmetic. All fields are copied at their declared widths.

Test Plan:
- Reset, then stream 4 beats (alu_out 0x10, 0x20, 0x30, 0x40) with out_ready=1 → out_valid from cycle 1; outputs match in order, one per cycle; in_ready stays 1.
- SKID=1: beat A (alu_out 0xA, mem_write=1) accepted, out_ready=0 for 3 cycles while B (0xB) is offered → B goes to skid, in_ready=0 next cycle; A held stable; on out_ready=1, A then B emerge on consecutive cycles; in_ready=1 one cycle after B moves to main.
- Flush while main=A and skid=B, with C offered → next cycle out_valid=0, all control outputs 0, in_ready=1; A, B, C never appear.
- Bubble: in_valid=0 after a beat with write_enable=1, rd=5 delivered → out_valid=0, out_write_enable=0, out_rd still 5.
- Async reset asserted mid-stall between clock edges → out_valid and every out_* go to 0 before the next clk edge; in_ready=1.
- SKID=0 with random in_valid and out_ready over 1000 cycles → scoreboard order exact, no loss or duplicates; in_ready equals !out_valid || out_ready on every cycle.
